// File: rtl/radio_te_pkg.sv
// Shared types and defaults for the radio timing engine pipeline stages.
package radio_te_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int GUARD_CYC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    ACTIVE = 2'd2,
    GUARD  = 2'd3
  } te_state_t;

endpackage

// File: rtl/radio_timing_sequencer_if.sv
// Request/status bundle between the timing controller (master) and the sequencer (slave).
interface radio_timing_sequencer_if #(
  parameter int CNT_W = radio_te_pkg::CNT_W_DEF
);

  logic             start;
  logic             mode_rx;
  logic [CNT_W-1:0] ramp_len;
  logic [CNT_W-1:0] active_len;
  logic             abort;
  logic             radio_enable1;
  logic             radio_rx_en1;
  logic             busy;
  logic             done;
  logic             start_err;

  modport master (
    output start, mode_rx, ramp_len, active_len, abort,
    input  radio_enable1, radio_rx_en1, busy, done, start_err
  );

  modport slave (
    input  start, mode_rx, ramp_len, active_len, abort,
    output radio_enable1, radio_rx_en1, busy, done, start_err
  );

endinterface

// File: rtl/te_down_counter.sv
// Loadable down counter with zero flag; load takes priority over decrement.
module te_down_counter #(
  parameter int CNT_W = radio_te_pkg::CNT_W_DEF
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/radio_timing_sequencer.sv
// Sequences one radio burst (ramp, active, guard) per accepted start and drives
// registered stage-1 enable strobes plus busy/done/start_err status.
module radio_timing_sequencer
  import radio_te_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF
) (
  input  logic                      ck,
  input  logic                      arst,
  radio_timing_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

  te_state_t        r_state;
  te_state_t        w_state_nxt;
  logic             r_mode_rx;
  logic [CNT_W-1:0] r_active_len;

  logic             w_accept;
  logic             w_mode_nxt;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;

  logic             r_radio_enable1, w_radio_enable1_nxt;
  logic             r_radio_rx_en1,  w_radio_rx_en1_nxt;
  logic             r_busy,          w_busy_nxt;
  logic             r_done,          w_done_nxt;
  logic             r_start_err,     w_start_err_nxt;

  assign w_accept   = (r_state == IDLE) && bus.start && !bus.abort;
  assign w_mode_nxt = w_accept ? bus.mode_rx : r_mode_rx;

  te_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .ck         (ck),
    .arst       (arst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_state      <= IDLE;
      r_mode_rx    <= 1'b0;
      r_active_len <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mode_rx    <= bus.mode_rx;
        r_active_len <= bus.active_len;
      end
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_state_nxt = (bus.ramp_len != '0) ? RAMP : ACTIVE;
      RAMP:   if (bus.abort) w_state_nxt = GUARD;
              else if (w_cnt_zero) w_state_nxt = ACTIVE;
      ACTIVE: if (bus.abort || (r_active_len != '0 && w_cnt_zero)) w_state_nxt = GUARD;
      GUARD:  if (w_cnt_zero) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Length loads only happen for non-zero lengths, so len-1 never wraps;
  // a zero active length simply leaves the counter parked at zero.
  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept && bus.ramp_len != '0) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = bus.ramp_len - 1'b1;
        end else if (w_accept && bus.active_len != '0) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = bus.active_len - 1'b1;
        end
      end
      RAMP: begin
        if (bus.abort) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = GUARD_LOAD;
        end else if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (r_active_len != '0) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = r_active_len - 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.abort || (r_active_len != '0 && w_cnt_zero)) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = GUARD_LOAD;
        end else if (r_active_len != '0) begin
          w_cnt_dec = 1'b1;
        end
      end
      GUARD: w_cnt_dec = !w_cnt_zero;
      default: ;
    endcase
  end

  always_comb begin
    w_radio_enable1_nxt = (w_state_nxt == RAMP) || (w_state_nxt == ACTIVE);
    w_radio_rx_en1_nxt  = (w_state_nxt == ACTIVE) && w_mode_nxt;
    w_busy_nxt          = (w_state_nxt != IDLE);
    w_done_nxt          = (r_state == GUARD) && (w_state_nxt == IDLE);
    w_start_err_nxt     = bus.start && (r_state != IDLE);
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_radio_enable1 <= 1'b0;
      r_radio_rx_en1  <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_start_err     <= 1'b0;
    end else begin
      r_radio_enable1 <= w_radio_enable1_nxt;
      r_radio_rx_en1  <= w_radio_rx_en1_nxt;
      r_busy          <= w_busy_nxt;
      r_done          <= w_done_nxt;
      r_start_err     <= w_start_err_nxt;
    end
  end

  assign bus.radio_enable1 = r_radio_enable1;
  assign bus.radio_rx_en1  = r_radio_rx_en1;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.start_err     = r_start_err;

endmodule

// File: tb/tb_radio_timing_sequencer.sv
// Self-checking bench: burst-timeline reference model compared every cycle,
// directed scenarios pinned with literal counts, then randomized traffic.
module tb_radio_timing_sequencer;
  import radio_te_pkg::*;

  localparam int CNT_W = 16;
  localparam int GUARD = 4;
  localparam int INF   = 1 << 30;

  logic ck   = 1'b0;
  logic arst = 1'b0;

  radio_timing_sequencer_if #(.CNT_W(CNT_W)) bus ();

  radio_timing_sequencer #(.CNT_W(CNT_W), .GUARD_CYC(GUARD)) dut (
    .ck   (ck),
    .arst (arst),
    .bus  (bus)
  );

  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is a timeline indexed by cycles since acceptance.
  // Enables cover cycles 1..stop, guard covers the GUARD cycles after stop.
  int m_t = 0, m_stop = 0, m_ramp = 0;
  bit m_rx = 0;
  bit exp_en = 0, exp_rx = 0, exp_busy = 0, exp_done = 0, exp_err = 0;

  initial forever begin
    @(posedge ck or posedge arst);
    if (arst) begin
      m_t = 0; m_stop = 0; m_ramp = 0; m_rx = 0;
      exp_done = 0; exp_err = 0;
    end else begin
      exp_done = 0;
      exp_err  = 0;
      if (m_t == 0) begin
        if (bus.start && !bus.abort) begin
          m_t    = 1;
          m_ramp = int'(bus.ramp_len);
          m_rx   = bus.mode_rx;
          m_stop = (bus.active_len == 0) ? INF : int'(bus.ramp_len) + int'(bus.active_len);
        end
      end else begin
        exp_err = bus.start;
        if (bus.abort && m_t <= m_stop) m_stop = m_t;
        if (m_t == m_stop + GUARD) begin
          m_t      = 0;
          exp_done = 1;
        end else begin
          m_t++;
        end
      end
    end
    exp_en   = (m_t != 0) && (m_t <= m_stop);
    exp_rx   = exp_en && m_rx && (m_t > m_ramp);
    exp_busy = (m_t != 0);
  end

  initial forever begin
    @(negedge ck);
    check("cycle_outputs {en,rx,busy,done,err}",
          {27'd0, bus.radio_enable1, bus.radio_rx_en1, bus.busy, bus.done, bus.start_err},
          {27'd0, exp_en, exp_rx, exp_busy, exp_done, exp_err});
  end

  int c_en, c_rx, c_busy, c_done, c_err;

  task automatic clr();
    c_en = 0; c_rx = 0; c_busy = 0; c_done = 0; c_err = 0;
  endtask

  task automatic step();
    @(negedge ck);
    c_en   += int'(bus.radio_enable1);
    c_rx   += int'(bus.radio_rx_en1);
    c_busy += int'(bus.busy);
    c_done += int'(bus.done);
    c_err  += int'(bus.start_err);
  endtask

  task automatic drive(input bit st, input bit rx, input int ramp, input int act, input bit ab);
    bus.start      = st;
    bus.mode_rx    = rx;
    bus.ramp_len   = CNT_W'(ramp);
    bus.active_len = CNT_W'(act);
    bus.abort      = ab;
  endtask

  task automatic idle();
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    #1 arst = 1'b1;
    repeat (3) @(negedge ck);
    check("reset_outputs", {bus.radio_enable1, bus.radio_rx_en1, bus.busy, bus.done, bus.start_err}, 0);
    arst = 1'b0;
    step();

    // TX burst: ramp 3, active 5
    clr();
    drive(1, 0, 3, 5, 0);
    step();
    check("tx_latency_en", bus.radio_enable1, 1);
    idle();
    repeat (15) step();
    check("tx_en_cycles", c_en, 8);
    check("tx_rx_cycles", c_rx, 0);
    check("tx_busy_cycles", c_busy, 12);
    check("tx_done_pulses", c_done, 1);

    // RX burst: ramp 2, active 4
    clr();
    drive(1, 1, 2, 4, 0);
    step();
    idle();
    step();
    check("rx_cycle2_rx_low", bus.radio_rx_en1, 0);
    step();
    check("rx_cycle3_rx_high", bus.radio_rx_en1, 1);
    repeat (11) step();
    check("rx_en_cycles", c_en, 6);
    check("rx_rx_cycles", c_rx, 4);
    check("rx_busy_cycles", c_busy, 10);
    check("rx_done_pulses", c_done, 1);

    // Zero lengths: continuous RX until abort
    clr();
    drive(1, 1, 0, 0, 0);
    step();
    check("zero_both_rise", {bus.radio_enable1, bus.radio_rx_en1}, 2'b11);
    idle();
    repeat (99) step();
    check("zero_en_hold", c_en, 100);
    check("zero_rx_hold", c_rx, 100);
    bus.abort = 1'b1;
    step();
    check("zero_abort_drop", {bus.radio_enable1, bus.radio_rx_en1, bus.busy}, 3'b001);
    idle();
    repeat (9) step();
    check("zero_busy_cycles", c_busy, 104);
    check("zero_done_pulses", c_done, 1);

    // Abort in RAMP cycle 3
    clr();
    drive(1, 1, 10, 5, 0);
    step();
    idle();
    step();
    step();
    bus.abort = 1'b1;
    step();
    check("ramp_abort_en_drop", bus.radio_enable1, 0);
    idle();
    repeat (8) step();
    check("ramp_abort_en_cycles", c_en, 3);
    check("ramp_abort_rx_cycles", c_rx, 0);
    check("ramp_abort_busy_cycles", c_busy, 7);
    check("ramp_abort_done", c_done, 1);

    // Start overrun: during ACTIVE and in last GUARD cycle
    clr();
    drive(1, 0, 1, 3, 0);
    step();
    idle();
    step();
    drive(1, 1, 7, 9, 0);
    step();
    idle();
    repeat (5) step();
    drive(1, 1, 5, 5, 0);
    step();
    check("overrun_done_err_c9", {bus.done, bus.start_err, bus.busy}, 3'b110);
    check("overrun_err_count", c_err, 2);
    check("overrun_en_cycles", c_en, 4);
    check("overrun_busy_cycles", c_busy, 8);
    drive(1, 0, 0, 2, 0);
    step();
    check("overrun_next_accept", bus.radio_enable1, 1);
    idle();
    repeat (8) step();
    check("overrun_total_en", c_en, 6);
    check("overrun_total_done", c_done, 2);

    // Reset asserted between edges in the middle of ACTIVE
    drive(1, 1, 1, 0, 0);
    step();
    idle();
    repeat (4) step();
    check("pre_reset_active", {bus.radio_enable1, bus.radio_rx_en1}, 2'b11);
    #2 arst = 1'b1;
    #1;
    check("async_reset_outputs", {bus.radio_enable1, bus.radio_rx_en1, bus.busy, bus.done, bus.start_err}, 0);
    repeat (2) @(negedge ck);
    arst = 1'b0;
    clr();
    drive(1, 1, 2, 3, 1);
    step();
    idle();
    repeat (4) step();
    check("start_abort_no_activity", c_busy + c_en + c_err, 0);

    // Randomized traffic
    repeat (3000) begin
      drive($urandom_range(7) == 0, 1'($urandom_range(1)), $urandom_range(0, 6),
            $urandom_range(0, 8), $urandom_range(15) == 0);
      step();
    end
    idle();
    repeat (120) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
